// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests on a
// valid/ready memory port, buffers up to DEPTH fetches, and presents the oldest
// returned instruction to decode. A redirect flushes the buffer and counts the
// in-flight responses that must be discarded when they come back.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic [31:0] out_instr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(2 * DEPTH) + 1;
    localparam int SW = DW + 1;

    // Wrap a buffer pointer at DEPTH (DEPTH is a power of two but may be 1).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    logic [DEPTH-1:0] alloc_r, filled_r, n_alloc_s, n_filled_s;
    logic [31:0]      pc_r [DEPTH];
    logic [31:0]      instr_r [DEPTH];
    logic [31:0]      n_pc_s [DEPTH];
    logic [31:0]      n_instr_s [DEPTH];
    logic [PW-1:0]    head_r, tail_r, fill_r, n_head_s, n_tail_s, n_fill_s;
    logic [CW-1:0]    count_r, pending_r, n_count_s, n_pending_s;
    logic [DW-1:0]    drop_r, n_drop_s;
    logic [31:0]      fetch_pc_r, n_fetch_pc_s;
    logic [SW-1:0]    inflight_s;
    logic             push_s, pop_s, fill_s, drop_rsp_s, redir_sub_s;
    logic [1:0]       unused_rpc_s;

    // Low address bits of the redirect target are forced to zero.
    assign unused_rpc_s = redirect_pc[1:0];

    // Allocated entries plus responses still to be discarded bound new requests.
    assign inflight_s     = SW'(count_r) + SW'(drop_r);
    assign imem_req_valid = rst_n && !redirect && (count_r < CW'(DEPTH))
                            && (inflight_s < SW'(2 * DEPTH));
    assign imem_addr      = fetch_pc_r;

    assign push_s      = imem_req_valid && imem_req_ready;
    assign pop_s       = out_valid && out_ready && !redirect;
    assign drop_rsp_s  = imem_rsp_valid && (drop_r != {DW{1'b0}});
    assign fill_s      = imem_rsp_valid && (drop_r == {DW{1'b0}}) && (pending_r != {CW{1'b0}});
    assign redir_sub_s = imem_rsp_valid && ((drop_r != {DW{1'b0}}) || (pending_r != {CW{1'b0}}));

    // Next-state of the fetch buffer; a redirect overrides pop, fill and push.
    always_comb begin
        n_alloc_s    = alloc_r;
        n_filled_s   = filled_r;
        n_pc_s       = pc_r;
        n_instr_s    = instr_r;
        n_head_s     = head_r;
        n_tail_s     = tail_r;
        n_fill_s     = fill_r;
        n_count_s    = count_r;
        n_pending_s  = pending_r;
        n_drop_s     = drop_r;
        n_fetch_pc_s = fetch_pc_r;
        if (redirect) begin
            n_alloc_s    = {DEPTH{1'b0}};
            n_filled_s   = {DEPTH{1'b0}};
            n_head_s     = {PW{1'b0}};
            n_tail_s     = {PW{1'b0}};
            n_fill_s     = {PW{1'b0}};
            n_count_s    = {CW{1'b0}};
            n_pending_s  = {CW{1'b0}};
            // Unfilled entries become stale responses; a response arriving now is one of them.
            n_drop_s     = drop_r + DW'(pending_r) - DW'(redir_sub_s);
            n_fetch_pc_s = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop_s) begin
                n_alloc_s[head_r]  = 1'b0;
                n_filled_s[head_r] = 1'b0;
                n_head_s           = ptr_inc(head_r);
            end else begin
                n_head_s = head_r;
            end
            if (fill_s) begin
                n_filled_s[fill_r] = 1'b1;
                n_instr_s[fill_r]  = imem_rsp_data;
                n_fill_s           = ptr_inc(fill_r);
            end else begin
                n_fill_s = fill_r;
            end
            if (push_s) begin
                n_alloc_s[tail_r]  = 1'b1;
                n_filled_s[tail_r] = 1'b0;
                n_pc_s[tail_r]     = fetch_pc_r;
                n_tail_s           = ptr_inc(tail_r);
                n_fetch_pc_s       = fetch_pc_r + 32'd4;
            end else begin
                n_tail_s     = tail_r;
                n_fetch_pc_s = fetch_pc_r;
            end
            n_count_s   = count_r + CW'(push_s) - CW'(pop_s);
            n_pending_s = pending_r + CW'(push_s) - CW'(fill_s);
            n_drop_s    = drop_r - DW'(drop_rsp_s);
        end
    end

    // State registers; outputs are registered from the next head entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_r     <= {DEPTH{1'b0}};
            filled_r    <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]    <= 32'h0;
                instr_r[i] <= 32'h0;
            end
            head_r      <= {PW{1'b0}};
            tail_r      <= {PW{1'b0}};
            fill_r      <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            pending_r   <= {CW{1'b0}};
            drop_r      <= {DW{1'b0}};
            fetch_pc_r  <= RESET_PC;
            out_valid   <= 1'b0;
            out_pc      <= 32'h0;
            out_pcplus4 <= 32'h0;
            out_instr   <= 32'h0;
        end else begin
            alloc_r     <= n_alloc_s;
            filled_r    <= n_filled_s;
            pc_r        <= n_pc_s;
            instr_r     <= n_instr_s;
            head_r      <= n_head_s;
            tail_r      <= n_tail_s;
            fill_r      <= n_fill_s;
            count_r     <= n_count_s;
            pending_r   <= n_pending_s;
            drop_r      <= n_drop_s;
            fetch_pc_r  <= n_fetch_pc_s;
            out_valid   <= n_alloc_s[n_head_s] && n_filled_s[n_head_s];
            out_pc      <= n_pc_s[n_head_s];
            out_pcplus4 <= n_pc_s[n_head_s] + 32'd4;
            out_instr   <= n_instr_s[n_head_s];
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a queue-level reference model checked every
// cycle, an in-order memory with configurable latency, and literal expectations
// for each scenario.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        out_valid, out_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rsp_data, out_pc, out_pcplus4, out_instr;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_instr(out_instr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int first_vld_cyc = -1;
    int redir_cyc = 0;

    // controls applied at the next falling edge
    logic        c_rst, c_redir, c_oready, c_rready;
    logic [31:0] c_rpc;

    typedef struct { logic [31:0] pc; bit filled; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    ent_t        mq[$];
    logic [31:0] m_fetch = RESET_PC;
    int          m_drop = 0;
    mreq_t       memq[$];

    int          acc_cyc[$];
    logic [31:0] acc_addr[$];
    int          pop_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_p4[$];
    logic [31:0] pop_instr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int iget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -999;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); acc_addr.delete();
        pop_cyc.delete(); pop_pc.delete(); pop_p4.delete(); pop_instr.delete();
    endtask

    // One clock cycle: drive, compare against the model, then advance model and memory.
    task automatic step();
        bit          m_rq, m_ev, rsp, m_push, m_pop, done;
        logic [31:0] rdata;
        int          pend;
        @(negedge clk);
        rst_n = c_rst; redirect = c_redir; redirect_pc = c_rpc;
        out_ready = c_oready; imem_req_ready = c_rready;
        rsp = c_rst && (memq.size() > 0) && (memq[0].due <= cyc);
        rdata = rsp ? mem_word(memq[0].addr) : 32'h0;
        imem_rsp_valid = rsp; imem_rsp_data = rdata;
        #1;
        m_rq = c_rst && !c_redir && (mq.size() < DEPTH) && ((mq.size() + m_drop) < 2 * DEPTH);
        m_ev = (mq.size() > 0) && mq[0].filled;
        chk("req_valid", imem_req_valid, m_rq);
        chk("imem_addr", imem_addr, m_fetch);
        chk("out_valid", out_valid, m_ev);
        if (m_ev) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_pcplus4", out_pcplus4, mq[0].pc + 32'd4);
            chk("out_instr", out_instr, mq[0].instr);
        end
        if (out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            acc_cyc.push_back(cyc); acc_addr.push_back(imem_addr);
            memq.push_back('{imem_addr, cyc + lat});
        end
        if (out_valid === 1'b1 && out_ready && !redirect) begin
            pop_cyc.push_back(cyc); pop_pc.push_back(out_pc);
            pop_p4.push_back(out_pcplus4); pop_instr.push_back(out_instr);
        end
        m_push = m_rq && c_rready;
        m_pop  = m_ev && c_oready && !c_redir;
        @(posedge clk);
        if (rsp) void'(memq.pop_front());
        if (!c_rst) memq.delete();
        if (!c_rst) begin
            mq.delete(); m_drop = 0; m_fetch = RESET_PC;
        end else if (c_redir) begin
            pend = 0;
            foreach (mq[i]) if (!mq[i].filled) pend++;
            m_drop = m_drop + pend;
            if (rsp && m_drop > 0) m_drop--;
            mq.delete();
            m_fetch = {c_rpc[31:2], 2'b00};
        end else begin
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else begin
                    done = 1'b0;
                    foreach (mq[i]) if (!done && !mq[i].filled) begin
                        mq[i].filled = 1'b1; mq[i].instr = rdata; done = 1'b1;
                    end
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back('{m_fetch, 1'b0, 32'h0});
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        c_rst = 1'b0; c_redir = 1'b0;
        run(1);
        c_rst = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        c_rst = 1'b0; c_redir = 1'b0; c_rpc = 32'h0; c_oready = 1'b1; c_rready = 1'b1;

        // Reset, then free run with 1-cycle memory
        run(2);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_pcplus4", out_pcplus4, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        c_rst = 1'b1; clear_logs(); first_vld_cyc = -1;
        run(8);
        chk("A_req0", qget(acc_addr, 0), 32'h0);
        chk("A_req1", qget(acc_addr, 1), 32'h4);
        chk("A_req2", qget(acc_addr, 2), 32'h8);
        chk("A_first_valid_delay", first_vld_cyc - iget(acc_cyc, 0), 32'd2);
        chk("A_pop0_pc", qget(pop_pc, 0), 32'h0);
        chk("A_pop0_pcplus4", qget(pop_p4, 0), 32'h4);
        chk("A_pop0_instr", qget(pop_instr, 0), 32'hC0DE_0000);
        chk("A_pop1_pc", qget(pop_pc, 1), 32'h4);
        chk("A_pop2_pc", qget(pop_pc, 2), 32'h8);

        // Stall: out_ready low for 5 cycles after a redirect to 0x40
        c_redir = 1'b1; c_rpc = 32'h40;
        run(1);
        c_redir = 1'b0; c_oready = 1'b0; clear_logs();
        run(5);
        #1;
        chk("B_stall_req_count", acc_addr.size(), 32'd2);
        chk("B_stall_req0", qget(acc_addr, 0), 32'h40);
        chk("B_stall_req1", qget(acc_addr, 1), 32'h44);
        chk("B_stall_req_valid", imem_req_valid, 1'b0);
        chk("B_stall_out_valid", out_valid, 1'b1);
        chk("B_stall_out_pc", out_pc, 32'h40);
        chk("B_stall_out_instr", out_instr, 32'hC0DE_0040);
        c_oready = 1'b1; clear_logs();
        run(6);
        chk("B_rel_pop0", qget(pop_pc, 0), 32'h40);
        chk("B_rel_pop1", qget(pop_pc, 1), 32'h44);
        chk("B_rel_pop2", qget(pop_pc, 2), 32'h48);
        chk("B_rel_no_gap", iget(pop_cyc, 1) - iget(pop_cyc, 0), 32'd1);

        // Redirect with 2 outstanding, 3-cycle memory
        do_reset();
        lat = 3; clear_logs();
        run(2);
        redir_cyc = cyc;
        c_redir = 1'b1; c_rpc = 32'h100;
        run(1);
        c_redir = 1'b0;
        run(12);
        chk("C_req0", qget(acc_addr, 0), 32'h0);
        chk("C_req1", qget(acc_addr, 1), 32'h4);
        chk("C_req_target", qget(acc_addr, 2), 32'h100);
        chk("C_req_target_cycle", iget(acc_cyc, 2) - redir_cyc, 32'd1);
        chk("C_pop0", qget(pop_pc, 0), 32'h100);
        chk("C_pop0_instr", qget(pop_instr, 0), 32'hC0DE_0100);
        chk("C_pop1", qget(pop_pc, 1), 32'h104);

        // Redirect in the same cycle as a response and a pop
        do_reset();
        lat = 1; clear_logs();
        run(2);
        redir_cyc = cyc;
        c_redir = 1'b1; c_rpc = 32'h300;
        run(1);
        c_redir = 1'b0;
        run(8);
        chk("D_req_target", qget(acc_addr, 2), 32'h300);
        chk("D_req_target_cycle", iget(acc_cyc, 2) - redir_cyc, 32'd1);
        chk("D_pop0", qget(pop_pc, 0), 32'h300);
        chk("D_pop0_cycle", iget(pop_cyc, 0) - redir_cyc, 32'd3);
        chk("D_pop1", qget(pop_pc, 1), 32'h304);

        // Backpressure on the request port, then an unaligned redirect
        do_reset();
        clear_logs();
        run(3);
        c_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run(1);
            #1;
            chk("E_addr_hold", imem_addr, 32'h8);
        end
        c_rready = 1'b1;
        run(1);
        chk("E_req_count", acc_addr.size(), 32'd3);
        chk("E_req_after_hold", qget(acc_addr, 2), 32'h8);
        c_redir = 1'b1; c_rpc = 32'h203;
        run(1);
        c_redir = 1'b0;
        run(3);
        chk("E_unaligned_req", qget(acc_addr, 3), 32'h200);
        chk("E_unaligned_next", qget(acc_addr, 4), 32'h204);

        // Reset in the middle of buffered traffic
        c_oready = 1'b0;
        run(4);
        c_rst = 1'b0;
        run(1);
        c_rst = 1'b1;
        #1;
        chk("F_out_valid", out_valid, 1'b0);
        chk("F_imem_addr", imem_addr, RESET_PC);
        c_oready = 1'b1; clear_logs();
        run(5);
        chk("F_req0", qget(acc_addr, 0), RESET_PC);
        chk("F_pop0", qget(pop_pc, 0), RESET_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
